// File: rtl/cpu_mc_issue.sv
// cpu_mc_issue: initiator side of the start/done multi-cycle execute handshake.
// Accepts one op from execute, pulses start to the selected unit, holds the
// pipeline while the unit works, captures its result on done and presents it
// for one writeback cycle. Only one op is in flight at a time.
// Optional feature: define CPU_MC_TIMEOUT_EN to abandon an op whose unit
// stays silent for TIMEOUT cycles in WAIT, pulsing timeout_err_o.
module cpu_mc_issue #(
  parameter int unsigned NUM_UNITS = 3,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      issue_valid_i,
  input  logic [1:0]                issue_unit_i,
  input  logic [4:0]                issue_rd_i,
  output logic                      issue_ready_o,
  input  logic                      flush_i,
  output logic [NUM_UNITS-1:0]      unit_start_o,
  input  logic [NUM_UNITS-1:0]      unit_done_i,
  input  logic [32*NUM_UNITS-1:0]   unit_res_i,
  output logic                      stall_o,
  output logic                      wb_valid_o,
  output logic [4:0]                wb_rd_o,
  output logic [31:0]               wb_data_o,
  output logic                      timeout_err_o
);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StWb} state_e;

  state_e      state_q;
  logic [1:0]  unit_q;
  logic [4:0]  rd_q;
  logic [31:0] data_q;
  logic [4:0]  wb_rd_q;

  logic        issue_ok;
  logic        done_sel;
  logic [31:0] res_sel;
  logic        tmo_hit;

  // Accept only in-range unit indices; flush kills an issue in the same cycle.
  assign issue_ok = issue_valid_i && !flush_i && ({30'b0, issue_unit_i} < NUM_UNITS);

  // Select the done level and result slice of the unit that owns the op.
  always_comb begin
    done_sel = 1'b0;
    res_sel  = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (unit_q == 2'(k)) begin
        done_sel = unit_done_i[k];
        res_sel  = unit_res_i[32*k +: 32];
      end
    end
  end

`ifdef CPU_MC_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;

  // Counts WAIT cycles without done; cleared while in START so WAIT starts at 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
    end else if (state_q == StStart) begin
      tmo_cnt_q <= '0;
    end else if (state_q == StWait && !done_sel) begin
      tmo_cnt_q <= tmo_cnt_q + 32'd1;
    end
  end

  // Done arriving on the limit cycle wins over the timeout.
  assign tmo_hit = (state_q == StWait) && !done_sel && !flush_i && (tmo_cnt_q == TIMEOUT - 1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo_hit        = 1'b0;
`endif

  assign timeout_err_o = tmo_hit;

  // Issue FSM and its captured operand/result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      unit_q  <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      wb_rd_q <= '0;
    end else if (flush_i) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (issue_ok) begin
            unit_q  <= issue_unit_i;
            rd_q    <= issue_rd_i;
            state_q <= StStart;
          end
        end
        StStart: state_q <= StWait;
        StWait: begin
          if (done_sel) begin
            data_q  <= res_sel;
            wb_rd_q <= rd_q;
            state_q <= StWb;
          end else if (tmo_hit) begin
            state_q <= StIdle;
          end
        end
        StWb:    state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // One-hot start pulse for the owning unit, suppressed by a same-cycle flush.
  always_comb begin
    unit_start_o = '0;
    if (state_q == StStart && !flush_i) begin
      for (int k = 0; k < NUM_UNITS; k++) begin
        if (unit_q == 2'(k)) unit_start_o[k] = 1'b1;
      end
    end
  end

  // WB releases the stall so the op retires in the same cycle it writes back.
  always_comb begin
    stall_o = (state_q == StStart) || (state_q == StWait) || ((state_q == StIdle) && issue_ok);
  end

  assign issue_ready_o = (state_q == StIdle);
  assign wb_valid_o    = (state_q == StWb) && !flush_i;
  assign wb_rd_o       = wb_rd_q;
  assign wb_data_o     = data_q;

endmodule

// File: tb/tb_cpu_mc_issue.sv
// Scoreboard bench for cpu_mc_issue: stimulus pushes expected writebacks,
// a negedge monitor pops and compares whenever wb_valid_o is high.
module tb_cpu_mc_issue;

  localparam int unsigned NU = 3;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          issue_valid_i;
  logic [1:0]    issue_unit_i;
  logic [4:0]    issue_rd_i;
  logic          issue_ready_o;
  logic          flush_i;
  logic [NU-1:0] unit_start_o;
  logic [NU-1:0] unit_done_i;
  logic [32*NU-1:0] unit_res_i;
  logic          stall_o;
  logic          wb_valid_o;
  logic [4:0]    wb_rd_o;
  logic [31:0]   wb_data_o;
  logic          timeout_err_o;

  cpu_mc_issue #(.NUM_UNITS(NU), .TIMEOUT(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .issue_valid_i (issue_valid_i),
    .issue_unit_i  (issue_unit_i),
    .issue_rd_i    (issue_rd_i),
    .issue_ready_o (issue_ready_o),
    .flush_i       (flush_i),
    .unit_start_o  (unit_start_o),
    .unit_done_i   (unit_done_i),
    .unit_res_i    (unit_res_i),
    .stall_o       (stall_o),
    .wb_valid_o    (wb_valid_o),
    .wb_rd_o       (wb_rd_o),
    .wb_data_o     (wb_data_o),
    .timeout_err_o (timeout_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every writeback must match the oldest expected entry, on time.
  always @(negedge clk) begin
    if (!rst_i && wb_valid_o) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb: got rd=%0d data=0x%0h expected none", wb_rd_o, wb_data_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wb_rd", 32'(wb_rd_o), 32'(e.rd));
        chk("wb_data", wb_data_o, e.data);
        chk("wb_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] u, input logic [4:0] rd);
    issue_valid_i = 1'b1;
    issue_unit_i  = u;
    issue_rd_i    = rd;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] d, input int at);
    exp_t e;
    e.rd = rd; e.data = d; e.cyc = at;
    q.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int bad;
    rst_i = 1'b1; issue_valid_i = 1'b0; issue_unit_i = '0; issue_rd_i = '0;
    flush_i = 1'b0; unit_done_i = '0; unit_res_i = '0;
    nxt(); nxt();
    rst_i = 1'b0;
    mid();
    chk("rst_ready", 32'(issue_ready_o), 32'd1);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_start", 32'(unit_start_o), 32'd0);
    chk("rst_wbv", 32'(wb_valid_o), 32'd0);
    chk("rst_wbdata", wb_data_o, 32'd0);
    chk("rst_wbrd", 32'(wb_rd_o), 32'd0);
    chk("rst_tmo", 32'(timeout_err_o), 32'd0);

    // Shift by 0: done in cycle 2, WB in cycle 3.
    nxt(); t0 = cyc;
    issue(2'd0, 5'd5); push(5'd5, 32'hDEADBEEF, t0 + 3);
    mid(); chk("t1_stall0", 32'(stall_o), 32'd1); chk("t1_start0", 32'(unit_start_o), 32'd0);
    nxt(); mid(); chk("t1_start1", 32'(unit_start_o), 32'b001); chk("t1_stall1", 32'(stall_o), 32'd1);
    nxt(); unit_done_i[0] = 1'b1; unit_res_i[31:0] = 32'hDEADBEEF;
    mid(); chk("t1_start2", 32'(unit_start_o), 32'd0); chk("t1_stall2", 32'(stall_o), 32'd1);
    nxt(); unit_done_i[0] = 1'b0;
    mid(); chk("t1_stall3", 32'(stall_o), 32'd0); chk("t1_start3", 32'(unit_start_o), 32'd0);
    nxt(); issue_valid_i = 1'b0;
    mid(); chk("t1_ready4", 32'(issue_ready_o), 32'd1); chk("t1_wbv4", 32'(wb_valid_o), 32'd0);
    chk("t1_hold_data", wb_data_o, 32'hDEADBEEF); chk("t1_hold_rd", 32'(wb_rd_o), 32'd5);

    // Shift 1 left by 7: done in cycle 9, WB in cycle 10.
    nxt(); t0 = cyc; unit_res_i[31:0] = 32'h0;
    issue(2'd0, 5'd3); push(5'd3, 32'h80, t0 + 10);
    for (int i = 1; i <= 9; i++) begin
      nxt();
      if (i == 9) begin unit_done_i[0] = 1'b1; unit_res_i[31:0] = 32'h80; end
      mid(); chk("t2_stall", 32'(stall_o), 32'd1);
    end
    nxt(); unit_done_i[0] = 1'b0;
    mid(); chk("t2_stall_wb", 32'(stall_o), 32'd0);
    nxt(); issue_valid_i = 1'b0;

    // Unit 1 holds done with 0x1234; unit 2 owns the op and finishes in cycle 5.
    unit_done_i[1] = 1'b1; unit_res_i[63:32] = 32'h1234;
    nxt(); t0 = cyc;
    issue(2'd2, 5'd7); push(5'd7, 32'hCAFE, t0 + 6);
    nxt(); mid(); chk("t3_start", 32'(unit_start_o), 32'b100);
    for (int i = 2; i <= 5; i++) begin
      if (i == 5) begin unit_done_i[2] = 1'b1; unit_res_i[95:64] = 32'hCAFE; end
      mid(); chk("t3_stall", 32'(stall_o), 32'd1);
      nxt();
    end
    unit_done_i = '0;
    mid(); chk("t3_stall_wb", 32'(stall_o), 32'd0);
    nxt(); issue_valid_i = 1'b0;

    // Flush in WAIT at cycle 3 (with a stray done); reissue rd=9 in cycle 4.
    nxt(); t0 = cyc;
    issue(2'd0, 5'd1);
    nxt(); nxt();
    nxt(); flush_i = 1'b1; issue_valid_i = 1'b0; unit_done_i[0] = 1'b1; unit_res_i[31:0] = 32'hBAD;
    mid(); chk("t4_wbv_flush", 32'(wb_valid_o), 32'd0);
    nxt(); flush_i = 1'b0; unit_done_i[0] = 1'b0;
    issue(2'd1, 5'd9); push(5'd9, 32'h99, t0 + 7);
    mid(); chk("t4_ready4", 32'(issue_ready_o), 32'd1); chk("t4_wbv4", 32'(wb_valid_o), 32'd0);
    chk("t4_hold_data", wb_data_o, 32'hCAFE);
    nxt(); mid(); chk("t4_start5", 32'(unit_start_o), 32'b010);
    nxt(); unit_done_i[1] = 1'b1; unit_res_i[63:32] = 32'h99;
    nxt(); unit_done_i[1] = 1'b0;
    nxt(); issue_valid_i = 1'b0;
    mid(); chk("t4_ready8", 32'(issue_ready_o), 32'd1);

    // Flush in the START cycle suppresses the start pulse.
    nxt(); issue(2'd0, 5'd2);
    nxt(); flush_i = 1'b1; issue_valid_i = 1'b0;
    mid(); chk("t5_start_flush", 32'(unit_start_o), 32'd0);
    nxt(); flush_i = 1'b0;
    mid(); chk("t5_ready", 32'(issue_ready_o), 32'd1); chk("t5_stall", 32'(stall_o), 32'd0);
    nxt(); mid(); chk("t5_nostart", 32'(unit_start_o), 32'd0);

    // Out-of-range unit index is ignored.
    nxt(); issue(2'd3, 5'd4);
    mid(); chk("t6_stall", 32'(stall_o), 32'd0);
    nxt(); mid(); chk("t6_start", 32'(unit_start_o), 32'd0); chk("t6_ready", 32'(issue_ready_o), 32'd1);
    issue_valid_i = 1'b0;

    // Flush together with issue in IDLE: no issue.
    nxt(); issue(2'd0, 5'd8); flush_i = 1'b1;
    mid(); chk("t7_stall", 32'(stall_o), 32'd0);
    nxt(); flush_i = 1'b0; issue_valid_i = 1'b0;
    mid(); chk("t7_start", 32'(unit_start_o), 32'd0); chk("t7_ready", 32'(issue_ready_o), 32'd1);

    // Unit never answers.
    nxt(); t0 = cyc; issue(2'd0, 5'd6);
`ifdef CPU_MC_TIMEOUT_EN
    begin
      int npulse = 0;
      int pcyc   = -1;
      for (int i = 0; i < 20; i++) begin
        mid();
        if (timeout_err_o) begin npulse++; pcyc = cyc - t0; end
        nxt();
        if (npulse != 0) issue_valid_i = 1'b0;
      end
      chk("t8_tmo_pulses", 32'(npulse), 32'd1);
      chk("t8_tmo_cycle", pcyc, 32'd5);
      mid(); chk("t8_stall", 32'(stall_o), 32'd0); chk("t8_ready", 32'(issue_ready_o), 32'd1);
    end
`else
    bad = 0;
    nxt();
    for (int i = 0; i < 200; i++) begin
      mid();
      if (stall_o !== 1'b1 || timeout_err_o !== 1'b0) bad++;
      nxt();
    end
    chk("t8_hang_bad_cycles", 32'(bad), 32'd0);
`endif

    // Reset mid-operation abandons the op.
    issue_valid_i = 1'b0;
    nxt(); issue(2'd1, 5'd10);
    nxt(); nxt(); rst_i = 1'b1; issue_valid_i = 1'b0;
    nxt(); rst_i = 1'b0;
    mid(); chk("t9_ready", 32'(issue_ready_o), 32'd1); chk("t9_stall", 32'(stall_o), 32'd0);
    chk("t9_wbdata", wb_data_o, 32'd0); chk("t9_wbrd", 32'(wb_rd_o), 32'd0);
    nxt(); unit_done_i[1] = 1'b1;
    mid(); chk("t9_start", 32'(unit_start_o), 32'd0); chk("t9_wbv", 32'(wb_valid_o), 32'd0);
    nxt(); unit_done_i = '0;
    nxt(); nxt();

    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
